// File: rtl/pla_inv_search.sv
// ---------------------------------------------------------------------------
// pla_inv_search
//
// Inverse search over an external 7-input / 9-output PLA.  Each candidate
// input vector 0..127 is driven on pla_x in ascending order.  The PLA's
// response pla_z is compared against a latched target pattern under a
// latched per-bit mask.  The search reports the first candidate that
// matches.
//
// Optional feature, selected by the macro PLA_INV_MULTI_MATCH_EN:
//   undefined : the scan stops at the first match; match_count is tied to 0.
//   defined   : the scan always covers all 128 candidates; found/result_x
//               still hold the first match, and match_count counts every
//               match, saturating at 128.
//
// Parameter:
//   PLA_LAT     cycles from driving pla_x to a valid pla_z (0..3)
//
// Ports:
//   clk         system clock, rising edge
//   rst         synchronous active-high reset
//   start       request a new search (only honoured in IDLE)
//   target      required PLA output pattern, latched on start
//   mask        per-bit compare enable (1 = compare), latched on start
//   pla_x       candidate vector to the PLA (0 outside SCAN)
//   pla_z       PLA response to pla_x
//   busy        high while a search is running
//   done        one-cycle completion pulse
//   found       a matching candidate was found (held until next start)
//   result_x    first matching candidate, else 0 (held until next start)
//   match_count number of matching candidates (0 without the macro)
// ---------------------------------------------------------------------------
module pla_inv_search #(
  parameter int PLA_LAT = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [8:0] target,
  input  logic [8:0] mask,
  output logic [6:0] pla_x,
  input  logic [8:0] pla_z,
  output logic       busy,
  output logic       done,
  output logic       found,
  output logic [6:0] result_x,
  output logic [7:0] match_count
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  localparam logic [1:0] LAT = 2'(PLA_LAT);

  state_t     state;
  logic [1:0] wait_cnt;
  logic [8:0] target_q;
  logic [8:0] mask_q;
  logic       is_match;
  logic       last_cand;

  // Only the masked bits of the response take part in the comparison.
  assign is_match  = ((pla_z ^ target_q) & mask_q) == 9'd0;
  assign last_cand = (pla_x == 7'd127);

`ifdef PLA_INV_MULTI_MATCH_EN
  logic [7:0] count_q;
  assign match_count = count_q;
`else
  assign match_count = 8'd0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      wait_cnt <= 2'd0;
      target_q <= 9'd0;
      mask_q   <= 9'd0;
      pla_x    <= 7'd0;
      busy     <= 1'b0;
      done     <= 1'b0;
      found    <= 1'b0;
      result_x <= 7'd0;
`ifdef PLA_INV_MULTI_MATCH_EN
      count_q  <= 8'd0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done  <= 1'b0;
          pla_x <= 7'd0;
          if (start) begin
            target_q <= target;
            mask_q   <= mask;
            wait_cnt <= 2'd0;
            found    <= 1'b0;
            result_x <= 7'd0;
`ifdef PLA_INV_MULTI_MATCH_EN
            count_q  <= 8'd0;
`endif
            busy     <= 1'b1;
            state    <= SCAN;
          end
        end

        SCAN: begin
          if (wait_cnt != LAT) begin
            wait_cnt <= wait_cnt + 2'd1;
          end else begin
            // pla_z now reflects the current candidate.
            wait_cnt <= 2'd0;
`ifdef PLA_INV_MULTI_MATCH_EN
            if (is_match) begin
              if (count_q < 8'd128)
                count_q <= count_q + 8'd1;
              if (!found) begin
                found    <= 1'b1;
                result_x <= pla_x;
              end
            end
            if (last_cand) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pla_x <= 7'd0;
            end else begin
              pla_x <= pla_x + 7'd1;
            end
`else
            if (is_match) begin
              found    <= 1'b1;
              result_x <= pla_x;
            end
            // Stop on the first hit or after candidate 127; never wrap to 0.
            if (is_match || last_cand) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pla_x <= 7'd0;
            end else begin
              pla_x <= pla_x + 7'd1;
            end
`endif
          end
        end

        DONE: begin
          done  <= 1'b0;
          pla_x <= 7'd0;
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pla_inv_search.sv
// ---------------------------------------------------------------------------
// tb_pla_inv_search
//
// Directed bench for pla_inv_search with PLA_LAT=1.  The PLA is modelled as
// z = {2'b00, x}, registered once, so candidate k produces pattern k.
// Expected values below are computed by hand from that model.
// ---------------------------------------------------------------------------
module tb_pla_inv_search;

  logic       clk;
  logic       rst;
  logic       start;
  logic [8:0] target;
  logic [8:0] mask;
  logic [6:0] pla_x;
  logic [8:0] pla_z;
  logic       busy;
  logic       done;
  logic       found;
  logic [6:0] result_x;
  logic [7:0] match_count;

  int checkCount = 0;
  int errorCount = 0;

  pla_inv_search #(.PLA_LAT(1)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .target      (target),
    .mask        (mask),
    .pla_x       (pla_x),
    .pla_z       (pla_z),
    .busy        (busy),
    .done        (done),
    .found       (found),
    .result_x    (result_x),
    .match_count (match_count)
  );

  // PLA stub: combinational identity, registered once.
  always_ff @(posedge clk) pla_z <= {2'b00, pla_x};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)",
               tag, observed, observed, expected, expected);
    end
  endtask

  // Launch a search and count cycles from the start edge to the done pulse.
  // extraStartAt >= 0 pulses start again at that cycle to verify it is ignored.
  // cycles = -1 if done never arrives; wrapped/busyLow flag illegal behaviour.
  task automatic applyStimulus(input logic [8:0] t, input logic [8:0] m,
                               input int extraStartAt, output int cycles,
                               output bit wrapped, output bit busyLow);
    logic [6:0] prevX;
    @(negedge clk);
    target = t;
    mask   = m;
    start  = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    cycles  = 0;
    wrapped = 1'b0;
    busyLow = 1'b0;
    prevX   = pla_x;
    while (1) begin
      @(posedge clk);
      #1;
      cycles++;
      if (cycles == extraStartAt) start = 1'b1;
      if (cycles == extraStartAt + 1) start = 1'b0;
      if (done) break;
      if (!busy) busyLow = 1'b1;
      if (pla_x < prevX) wrapped = 1'b1;
      prevX = pla_x;
      if (cycles > 400) begin
        cycles = -1;
        break;
      end
    end
    start = 1'b0;
  endtask

  // Verify the one-cycle pulse shape and that results hold into IDLE.
  task automatic checkDoneShape(input string tag, input logic expFound,
                                input logic [6:0] expResult);
    checkOutput({tag, "_busy_at_done"}, busy, 0);
    checkOutput({tag, "_x_at_done"}, pla_x, 0);
    checkOutput({tag, "_found"}, found, expFound);
    checkOutput({tag, "_result"}, result_x, expResult);
    @(posedge clk);
    #1;
    checkOutput({tag, "_done_one_cycle"}, done, 0);
    checkOutput({tag, "_busy_after"}, busy, 0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput({tag, "_found_held"}, found, expFound);
    checkOutput({tag, "_result_held"}, result_x, expResult);
  endtask

  int  cycles;
  bit  wrapped;
  bit  busyLow;
  int  guard;
  bit  sawDone;

  initial begin
    rst    = 1'b1;
    start  = 1'b0;
    target = 9'd0;
    mask   = 9'd0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_found", found, 0);
    checkOutput("reset_result", result_x, 0);
    checkOutput("reset_pla_x", pla_x, 0);
    checkOutput("reset_count", match_count, 0);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    // Match at candidate 0x5A: 2*(90+1) = 182 cycles.
    applyStimulus(9'h05A, 9'h1FF, -1, cycles, wrapped, busyLow);
    checkOutput("hit5A_cycles", cycles, 182);
    checkOutput("hit5A_busy", busyLow, 0);
    checkOutput("hit5A_count", match_count, 0);
    checkDoneShape("hit5A", 1'b1, 7'h5A);

    // Unreachable pattern: full scan, 2*128 = 256 cycles, no wrap.
    applyStimulus(9'h180, 9'h1FF, -1, cycles, wrapped, busyLow);
    checkOutput("miss_cycles", cycles, 256);
    checkOutput("miss_nowrap", wrapped, 0);
    checkOutput("miss_busy", busyLow, 0);
    checkDoneShape("miss", 1'b0, 7'h00);

    // Empty mask matches candidate 0 after 2 cycles.
    applyStimulus(9'h1FF, 9'h000, -1, cycles, wrapped, busyLow);
    checkOutput("mask0_cycles", cycles, 2);
    checkDoneShape("mask0", 1'b1, 7'h00);

    // Start pulse during SCAN is ignored; timing matches the single start.
    applyStimulus(9'h05A, 9'h1FF, 10, cycles, wrapped, busyLow);
    checkOutput("restart_cycles", cycles, 182);
    checkDoneShape("restart", 1'b1, 7'h5A);

    // Abort a search at candidate 40 with reset.
    @(negedge clk);
    target = 9'h180;
    mask   = 9'h1FF;
    start  = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    guard = 0;
    while (pla_x != 7'd40 && guard < 300) begin
      @(posedge clk);
      #1;
      guard++;
    end
    checkOutput("abort_reached40", pla_x, 40);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_pla_x", pla_x, 0);
    checkOutput("abort_found", found, 0);
    sawDone = 1'b0;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (done) sawDone = 1'b1;
    end
    checkOutput("abort_no_done", sawDone, 0);
    applyStimulus(9'h003, 9'h1FF, -1, cycles, wrapped, busyLow);
    checkOutput("after_abort_cycles", cycles, 8);
    checkDoneShape("after_abort", 1'b1, 7'h03);

    // Bit 0 compared only: odd candidates match.
    applyStimulus(9'h001, 9'h001, -1, cycles, wrapped, busyLow);
`ifdef PLA_INV_MULTI_MATCH_EN
    checkOutput("odd_cycles", cycles, 256);
    checkOutput("odd_count", match_count, 64);
`else
    checkOutput("odd_cycles", cycles, 4);
    checkOutput("odd_count", match_count, 0);
`endif
    checkDoneShape("odd", 1'b1, 7'h01);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
